// File: rtl/jtvigil_sdram_bank_ctrl.sv
// SDRAM responder for the four-bank game request port and the download port.
// It runs power-up init and periodic auto-refresh. Each access is a single
// ACT -> RD/WR (auto-precharge) burst of two words. The access has a fixed
// length, so the next command always starts from a clean precharged bank.
module jtvigil_sdram_bank_ctrl #(
  parameter int INIT_WAIT   = 9600,
  parameter int REFRESH_CNT = 374,
  parameter int T_RCD       = 2,
  parameter int T_RP        = 2,
  parameter int T_RFC       = 7,
  parameter int CL          = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [21:0] ba0_addr,
  input  logic [21:0] ba1_addr,
  input  logic [21:0] ba2_addr,
  input  logic [21:0] ba3_addr,
  input  logic [3:0]  ba_rd,
  input  logic        ba_wr,
  input  logic [15:0] ba0_din,
  input  logic [1:0]  ba0_din_m,
  output logic [3:0]  ba_ack,
  output logic [3:0]  ba_dst,
  output logic [3:0]  ba_dok,
  output logic [3:0]  ba_rdy,
  output logic [15:0] data_read,
  input  logic        downloading,
  input  logic [21:0] prog_addr,
  input  logic [15:0] prog_data,
  input  logic [1:0]  prog_mask,
  input  logic [1:0]  prog_ba,
  input  logic        prog_we,
  input  logic        prog_rd,
  output logic        prog_ack,
  output logic        prog_dst,
  output logic        prog_dok,
  output logic        prog_rdy,
  output logic [12:0] sdram_a,
  output logic [1:0]  sdram_ba,
  output logic [1:0]  sdram_dqm,
  output logic        sdram_ncs,
  output logic        sdram_nras,
  output logic        sdram_ncas,
  output logic        sdram_nwe,
  output logic        sdram_cke,
  input  logic [15:0] sdram_din,
  output logic [15:0] sdram_dout,
  output logic        sdram_dq_oe
);
  localparam int CW = $clog2(INIT_WAIT + T_RFC + T_RCD + T_RP + CL + 8);
  localparam int RW = $clog2(REFRESH_CNT + 1);

  localparam logic [2:0] S_WAIT = 3'd0, S_PRE = 3'd1, S_REF1 = 3'd2, S_REF2 = 3'd3,
                         S_MODE = 3'd4, S_IDLE = 3'd5, S_ACC = 3'd6, S_REF = 3'd7;
  // {ncs, nras, ncas, nwe}
  localparam logic [3:0] C_INH = 4'b1111, C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD = 4'b0101,
                         C_WR  = 4'b0100, C_PRE = 4'b0010, C_REF = 4'b0001, C_MRS = 4'b0000;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  logic          ref_pend_q, ref_pend_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [4:0]    port_q, port_d;   // one-hot: banks 0..3, bit 4 = prog
  logic          wr_q, wr_d;
  logic [8:0]    col_q, col_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [1:0]    wmask_q, wmask_d;
  logic [3:0]    cmd_q, cmd_d;
  logic [12:0]   a_q, a_d;
  logic [1:0]    ba_q, ba_d, dqm_q, dqm_d;
  logic [15:0]   dout_q, dout_d, dr_q, dr_d;
  logic          oe_q, oe_d;
  logic [4:0]    ack_q, ack_d, dst_q, dst_d, dok_q, dok_d, rdy_q, rdy_d;

  logic [4:0]  gnt;
  logic        g_wr, rr_hit;
  logic [21:0] g_addr;
  logic [1:0]  g_ba, g_mask, rr_idx, idx;
  logic [15:0] g_data;

  // Request selection: prog while downloading, then bank-0 write, then round-robin reads
  always_comb begin
    gnt    = '0;
    g_wr   = 1'b0;
    g_addr = ba0_addr;
    g_ba   = 2'd0;
    g_data = ba0_din;
    g_mask = ba0_din_m;
    rr_hit = 1'b0;
    rr_idx = ptr_q;
    idx    = ptr_q;
    if (downloading && (prog_we || prog_rd)) begin
      gnt[4] = 1'b1;
      g_wr   = prog_we;
      g_addr = prog_addr;
      g_ba   = prog_ba;
      g_data = prog_data;
      g_mask = prog_mask;
    end else if (ba_wr) begin
      gnt[0] = 1'b1;
      g_wr   = 1'b1;
    end else begin
      for (int k = 0; k < 4; k++) begin
        idx = ptr_q + 2'(k);
        if (!rr_hit && ba_rd[idx]) begin
          rr_hit = 1'b1;
          rr_idx = idx;
        end
      end
      if (rr_hit) begin
        gnt[rr_idx] = 1'b1;
        g_ba        = rr_idx;
        case (rr_idx)
          2'd0:    g_addr = ba0_addr;
          2'd1:    g_addr = ba1_addr;
          2'd2:    g_addr = ba2_addr;
          default: g_addr = ba3_addr;
        endcase
      end
    end
  end

  // Sequencer: init, refresh, access timing and all registered pin/handshake values
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CW'(1);
    ref_cnt_d  = (ref_cnt_q == '0) ? RW'(REFRESH_CNT) : ref_cnt_q - RW'(1);
    ref_pend_d = ref_pend_q | (ref_cnt_q == '0);
    ptr_d      = ptr_q;
    port_d     = port_q;
    wr_d       = wr_q;
    col_d      = col_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    cmd_d      = C_NOP;
    a_d        = a_q;
    ba_d       = ba_q;
    dqm_d      = 2'b11;
    dout_d     = dout_q;
    oe_d       = 1'b0;
    dr_d       = dr_q;
    ack_d      = '0;
    dst_d      = '0;
    dok_d      = '0;
    rdy_d      = '0;
    case (state_q)
      S_WAIT: begin
        cmd_d = C_INH;
        if (cnt_q == CW'(INIT_WAIT - 1)) begin
          state_d = S_PRE;  cnt_d = '0;  cmd_d = C_PRE;  a_d = 13'h400;
        end
      end
      S_PRE:  if (cnt_q == CW'(T_RP - 1)) begin
        state_d = S_REF1; cnt_d = '0; cmd_d = C_REF;
      end
      S_REF1: if (cnt_q == CW'(T_RFC - 1)) begin
        state_d = S_REF2; cnt_d = '0; cmd_d = C_REF;
      end
      S_REF2: if (cnt_q == CW'(T_RFC - 1)) begin
        // BL2, sequential, CL2
        state_d = S_MODE; cnt_d = '0; cmd_d = C_MRS; a_d = 13'h021; ba_d = 2'd0;
      end
      S_MODE: if (cnt_q == CW'(1)) begin
        state_d = S_IDLE; cnt_d = '0;
      end
      S_IDLE: begin
        cnt_d = '0;
        if (ref_pend_q && !gnt[4]) begin
          state_d    = S_REF;
          cmd_d      = C_REF;
          ref_pend_d = (ref_cnt_q == '0);
        end else if (|gnt) begin
          state_d = S_ACC;
          cmd_d   = C_ACT;
          a_d     = g_addr[21:9];
          ba_d    = g_ba;
          dqm_d   = g_wr ? 2'b11 : 2'b00;
          ack_d   = gnt;
          port_d  = gnt;
          wr_d    = g_wr;
          col_d   = g_addr[8:0];
          wdata_d = g_data;
          wmask_d = g_mask;
          if (rr_hit) ptr_d = rr_idx + 2'd1;
        end
      end
      S_ACC: begin
        dqm_d = wr_q ? 2'b11 : 2'b00;
        if (cnt_q == CW'(T_RCD - 1)) begin
          cmd_d = wr_q ? C_WR : C_RD;
          a_d   = {3'b001, 1'b0, col_q};
          if (wr_q) begin
            oe_d = 1'b1;  dout_d = wdata_q;  dqm_d = wmask_q;
          end
        end
        // second burst word of a write is masked off
        if (wr_q && cnt_q == CW'(T_RCD)) begin
          oe_d = 1'b1;  rdy_d = port_q;
        end
        if (!wr_q && cnt_q == CW'(T_RCD + CL)) begin
          dr_d = sdram_din;  dst_d = port_q;  dok_d = port_q;
        end
        if (!wr_q && cnt_q == CW'(T_RCD + CL + 1)) begin
          dr_d = sdram_din;  dok_d = port_q;  rdy_d = port_q;
        end
        if (cnt_q == CW'(T_RCD + CL + 1 + T_RP)) begin
          state_d = S_IDLE;  cnt_d = '0;
        end
      end
      S_REF:  if (cnt_q == CW'(T_RFC - 1)) begin
        state_d = S_IDLE; cnt_d = '0;
      end
      default: begin
        state_d = S_WAIT; cnt_d = '0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_WAIT;
      cnt_q      <= '0;
      ref_cnt_q  <= RW'(REFRESH_CNT);
      ref_pend_q <= 1'b0;
      ptr_q      <= 2'd0;
      port_q     <= '0;
      wr_q       <= 1'b0;
      col_q      <= '0;
      wdata_q    <= '0;
      wmask_q    <= 2'b11;
      cmd_q      <= C_INH;
      a_q        <= '0;
      ba_q       <= '0;
      dqm_q      <= 2'b11;
      dout_q     <= '0;
      oe_q       <= 1'b0;
      dr_q       <= '0;
      ack_q      <= '0;
      dst_q      <= '0;
      dok_q      <= '0;
      rdy_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ref_cnt_q  <= ref_cnt_d;
      ref_pend_q <= ref_pend_d;
      ptr_q      <= ptr_d;
      port_q     <= port_d;
      wr_q       <= wr_d;
      col_q      <= col_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      cmd_q      <= cmd_d;
      a_q        <= a_d;
      ba_q       <= ba_d;
      dqm_q      <= dqm_d;
      dout_q     <= dout_d;
      oe_q       <= oe_d;
      dr_q       <= dr_d;
      ack_q      <= ack_d;
      dst_q      <= dst_d;
      dok_q      <= dok_d;
      rdy_q      <= rdy_d;
    end
  end

  assign {sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe} = cmd_q;
  assign sdram_cke   = 1'b1;
  assign sdram_a     = a_q;
  assign sdram_ba    = ba_q;
  assign sdram_dqm   = dqm_q;
  assign sdram_dout  = dout_q;
  assign sdram_dq_oe = oe_q;
  assign data_read   = dr_q;
  assign ba_ack      = ack_q[3:0];
  assign ba_dst      = dst_q[3:0];
  assign ba_dok      = dok_q[3:0];
  assign ba_rdy      = rdy_q[3:0];
  assign prog_ack    = ack_q[4];
  assign prog_dst    = dst_q[4];
  assign prog_dok    = dok_q[4];
  assign prog_rdy    = rdy_q[4];
endmodule

// File: tb/tb_jtvigil_sdram_bank_ctrl.sv
// Bench for jtvigil_sdram_bank_ctrl: small SDRAM read model, a vector table
// for single read/write timelines, and directed sequences for init,
// round-robin, refresh spacing, prog priority and reset during an access.
module tb_jtvigil_sdram_bank_ctrl;
  localparam int IW = 100, RC = 100, T_RCD = 2, T_RP = 2, T_RFC = 7, CL = 2;
  localparam logic [3:0] C_INH = 4'b1111, C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD = 4'b0101,
                         C_WR  = 4'b0100, C_PRE = 4'b0010, C_REF = 4'b0001, C_MRS = 4'b0000;

  logic clk, rst_n;
  logic [21:0] ba0_addr, ba1_addr, ba2_addr, ba3_addr, prog_addr;
  logic [3:0]  ba_rd, ba_ack, ba_dst, ba_dok, ba_rdy;
  logic        ba_wr, downloading, prog_we, prog_rd;
  logic [15:0] ba0_din, data_read, prog_data, sdram_din, sdram_dout;
  logic [1:0]  ba0_din_m, prog_mask, prog_ba, sdram_ba, sdram_dqm;
  logic        prog_ack, prog_dst, prog_dok, prog_rdy;
  logic [12:0] sdram_a;
  logic        sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe, sdram_cke, sdram_dq_oe;
  logic [3:0]  cmd;
  logic [4:0]  ackv;

  assign cmd  = {sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe};
  assign ackv = {prog_ack, ba_ack};

  jtvigil_sdram_bank_ctrl #(.INIT_WAIT(IW), .REFRESH_CNT(RC), .T_RCD(T_RCD), .T_RP(T_RP),
                            .T_RFC(T_RFC), .CL(CL)) dut (
    .clk(clk), .rst_n(rst_n),
    .ba0_addr(ba0_addr), .ba1_addr(ba1_addr), .ba2_addr(ba2_addr), .ba3_addr(ba3_addr),
    .ba_rd(ba_rd), .ba_wr(ba_wr), .ba0_din(ba0_din), .ba0_din_m(ba0_din_m),
    .ba_ack(ba_ack), .ba_dst(ba_dst), .ba_dok(ba_dok), .ba_rdy(ba_rdy), .data_read(data_read),
    .downloading(downloading), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_mask(prog_mask), .prog_ba(prog_ba), .prog_we(prog_we), .prog_rd(prog_rd),
    .prog_ack(prog_ack), .prog_dst(prog_dst), .prog_dok(prog_dok), .prog_rdy(prog_rdy),
    .sdram_a(sdram_a), .sdram_ba(sdram_ba), .sdram_dqm(sdram_dqm),
    .sdram_ncs(sdram_ncs), .sdram_nras(sdram_nras), .sdram_ncas(sdram_ncas),
    .sdram_nwe(sdram_nwe), .sdram_cke(sdram_cke), .sdram_din(sdram_din),
    .sdram_dout(sdram_dout), .sdram_dq_oe(sdram_dq_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0, passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  // Memory contents as seen by the model; one fixed location holds BEEF/CAFE
  function automatic logic [15:0] mdl(input logic [1:0] b, input logic [12:0] row,
                                      input logic [8:0] col, input logic w);
    if (b == 2'd2 && row == 13'h091 && col == 9'h145) return w ? 16'hCAFE : 16'hBEEF;
    return {b, 5'(row), col} ^ (w ? 16'h5A5A : 16'h0000);
  endfunction

  // SDRAM model: CL=2 read burst of two words
  logic [12:0] row_at [4];
  int cyc = 0, rd_cyc = -100;
  logic [1:0] rd_b = 2'd0;
  logic [8:0] rd_col = 9'd0;
  initial sdram_din = 16'h0;
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (cmd == C_ACT) row_at[sdram_ba] = sdram_a;
    if (cmd == C_RD) begin rd_cyc = cyc; rd_b = sdram_ba; rd_col = sdram_a[8:0]; end
    if (cyc == rd_cyc + CL)          sdram_din = mdl(rd_b, row_at[rd_b], rd_col, 1'b0);
    else if (cyc == rd_cyc + CL + 1) sdram_din = mdl(rd_b, row_at[rd_b], rd_col, 1'b1);
    else                             sdram_din = 16'h0;
  end

  typedef struct {
    logic [3:0] cmd; logic [12:0] a; logic [1:0] ba; logic ca;
    logic [3:0] ack, dst, dok, rdy; logic [1:0] dqm; logic oe;
    logic [15:0] dout, dr;
  } vec_t;
  vec_t v [16];

  task automatic wait_ack(input logic [4:0] m, input int maxc, input string nm);
    bit ok = 0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge clk);
      if ((ackv & m) != 0) ok = 1;
    end
    chk(nm, ok, 1);
  endtask

  // Called on the negedge of the ACT cycle; walks one cycle per entry
  task automatic run_seq(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("v%0d.cmd", first + i), cmd, v[first+i].cmd);
      if (v[first+i].ca) begin
        chk($sformatf("v%0d.a", first + i), sdram_a, v[first+i].a);
        chk($sformatf("v%0d.ba", first + i), sdram_ba, v[first+i].ba);
      end
      chk($sformatf("v%0d.ack", first + i), ba_ack, v[first+i].ack);
      chk($sformatf("v%0d.dst", first + i), ba_dst, v[first+i].dst);
      chk($sformatf("v%0d.dok", first + i), ba_dok, v[first+i].dok);
      chk($sformatf("v%0d.rdy", first + i), ba_rdy, v[first+i].rdy);
      chk($sformatf("v%0d.dqm", first + i), sdram_dqm, v[first+i].dqm);
      chk($sformatf("v%0d.oe", first + i), sdram_dq_oe, v[first+i].oe);
      if (v[first+i].oe)  chk($sformatf("v%0d.dout", first + i), sdram_dout, v[first+i].dout);
      if (v[first+i].dok != 0) chk($sformatf("v%0d.data", first + i), data_read, v[first+i].dr);
    end
  endtask

  task automatic check_init(input string tag);
    int n, bad;
    n = 0; bad = 0;
    while (n < IW + 20) begin
      @(negedge clk); n++;
      if (cmd == C_PRE) break;
      if (cmd != C_INH) bad++;
      if (ackv != 0) bad++;
    end
    chk({tag, "_inhibit_cycles"}, n, IW);
    chk({tag, "_no_cmd_or_ack_before_pre"}, bad, 0);
    chk({tag, "_pre_a10"}, sdram_a, 13'h400);
    n = 0; while (n < 20 && cmd != C_REF) begin @(negedge clk); n++; end
    chk({tag, "_pre_to_ref"}, n, T_RP);
    n = 0; do begin @(negedge clk); n++; end while (n < 20 && cmd != C_REF);
    chk({tag, "_ref_to_ref"}, n, T_RFC);
    n = 0; do begin @(negedge clk); n++; end while (n < 20 && cmd != C_MRS);
    chk({tag, "_ref_to_mode"}, n, T_RFC);
    chk({tag, "_mode_word"}, sdram_a, 13'h021);
  endtask

  logic [21:0] addrs [4];
  logic [21:0] pa;
  int wcnt [4];
  int order [$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ndone, nref, last_ref, last_ack;
    // read bank 2 @0x12345
    v[0] = '{C_ACT, 13'h091, 2'd2, 1'b1, 4'b0100, 4'b0, 4'b0, 4'b0, 2'b00, 1'b0, 16'h0, 16'h0};
    v[1] = '{C_NOP, 13'h0, 2'd0, 1'b0, 4'b0, 4'b0, 4'b0, 4'b0, 2'b00, 1'b0, 16'h0, 16'h0};
    v[2] = '{C_RD, 13'h545, 2'd2, 1'b1, 4'b0, 4'b0, 4'b0, 4'b0, 2'b00, 1'b0, 16'h0, 16'h0};
    v[3] = v[1];
    v[4] = v[1];
    v[5] = '{C_NOP, 13'h0, 2'd0, 1'b0, 4'b0, 4'b0100, 4'b0100, 4'b0, 2'b00, 1'b0, 16'h0, 16'hBEEF};
    v[6] = '{C_NOP, 13'h0, 2'd0, 1'b0, 4'b0, 4'b0, 4'b0100, 4'b0100, 2'b00, 1'b0, 16'h0, 16'hCAFE};
    v[7] = v[1];
    // write bank 0 @0x2A0F3, data 0x1234, mask 01
    v[8]  = '{C_ACT, 13'h150, 2'd0, 1'b1, 4'b0001, 4'b0, 4'b0, 4'b0, 2'b11, 1'b0, 16'h0, 16'h0};
    v[9]  = '{C_NOP, 13'h0, 2'd0, 1'b0, 4'b0, 4'b0, 4'b0, 4'b0, 2'b11, 1'b0, 16'h0, 16'h0};
    v[10] = '{C_WR, 13'h4F3, 2'd0, 1'b1, 4'b0, 4'b0, 4'b0, 4'b0, 2'b01, 1'b1, 16'h1234, 16'h0};
    v[11] = '{C_NOP, 13'h0, 2'd0, 1'b0, 4'b0, 4'b0, 4'b0, 4'b0001, 2'b11, 1'b1, 16'h1234, 16'h0};
    for (int i = 12; i < 16; i++) v[i] = v[9];

    rst_n = 1'b0; ba_rd = '0; ba_wr = 1'b0; ba0_din = '0; ba0_din_m = '0;
    ba0_addr = '0; ba1_addr = '0; ba2_addr = '0; ba3_addr = '0;
    downloading = 1'b0; prog_addr = '0; prog_data = '0; prog_mask = '0; prog_ba = '0;
    prog_we = 1'b0; prog_rd = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd", cmd, C_INH);
    chk("rst_cke", sdram_cke, 1);
    chk("rst_dqm", sdram_dqm, 2'b11);
    chk("rst_a", sdram_a, 0);
    chk("rst_ba", sdram_ba, 0);
    chk("rst_oe", sdram_dq_oe, 0);
    chk("rst_data", data_read, 0);
    chk("rst_hs", {ackv, ba_dst, ba_dok, ba_rdy, prog_dst, prog_dok, prog_rdy}, 0);
    rst_n = 1'b1;
    check_init("init");

    // round-robin: all four banks at once
    addrs[0] = 22'h00100; addrs[1] = 22'h01234; addrs[2] = 22'h3F00A; addrs[3] = 22'h20001;
    ba0_addr = addrs[0]; ba1_addr = addrs[1]; ba2_addr = addrs[2]; ba3_addr = addrs[3];
    for (int b = 0; b < 4; b++) wcnt[b] = 0;
    ba_rd = 4'hF; ndone = 0;
    for (int c = 0; c < 300 && ndone < 4; c++) begin
      @(negedge clk);
      for (int b = 0; b < 4; b++) begin
        if (ba_ack[b]) begin order.push_back(b); ba_rd[b] = 1'b0; end
        if (ba_dok[b]) begin
          chk($sformatf("rr_data_b%0d_w%0d", b, wcnt[b]), data_read,
              mdl(2'(b), addrs[b][21:9], addrs[b][8:0], wcnt[b] != 0));
          wcnt[b]++;
        end
        if (ba_rdy[b]) ndone++;
      end
    end
    chk("rr_ack_count", order.size(), 4);
    for (int i = 0; i < 4 && i < order.size(); i++) chk($sformatf("rr_order%0d", i), order[i], i);
    for (int b = 0; b < 4; b++) chk($sformatf("rr_words_b%0d", b), wcnt[b], 2);

    // single read, table-checked
    ba2_addr = 22'h12345; ba_rd = 4'b0100;
    wait_ack(5'b00100, 60, "rd_ack_wait");
    ba_rd = 4'b0000;
    run_seq(0, 8);

    // single masked write, table-checked
    ba0_addr = 22'h2A0F3; ba0_din = 16'h1234; ba0_din_m = 2'b01; ba_wr = 1'b1;
    wait_ack(5'b00001, 60, "wr_ack_wait");
    ba_wr = 1'b0;
    run_seq(8, 8);

    // continuous reads with refresh interleaved
    ba0_addr = 22'h00042; ba_rd = 4'b0001;
    nref = 0; last_ref = -1000; last_ack = -1000;
    for (int c = 0; c < 450; c++) begin
      @(negedge clk);
      if (cmd == C_REF) begin
        if (nref > 0) chk("ref_gap", (c - last_ref) <= RC + 10, 1);
        chk("ref_after_full_access", (c - last_ack) >= 8, 1);
        last_ref = c; nref++;
      end
      if (ba_ack[0]) begin
        chk("no_ack_in_trfc", (c - last_ref) > T_RFC, 1);
        last_ack = c;
      end
      if (ba_rdy[0]) chk("rdy_latency", c - last_ack, 6);
    end
    chk("ref_count", nref >= 3, 1);
    ba_rd = 4'b0000;
    repeat (12) @(negedge clk);

    // prog port beats a simultaneous bank read
    pa = 22'h0ABCD;
    prog_addr = pa; prog_ba = 2'd1; downloading = 1'b1; prog_rd = 1'b1;
    ba1_addr = 22'h00777; ba_rd = 4'b0010;
    wait_ack(5'b11111, 60, "prog_ack_wait");
    chk("prog_first", ackv, 5'b10000);
    chk("prog_act_ba", sdram_ba, 2'd1);
    chk("prog_act_row", sdram_a, pa[21:9]);
    prog_rd = 1'b0;
    repeat (5) @(negedge clk);
    chk("prog_dst", {prog_dst, prog_dok}, 2'b11);
    chk("prog_w0", data_read, mdl(2'd1, pa[21:9], pa[8:0], 1'b0));
    @(negedge clk);
    chk("prog_rdy", {prog_dst, prog_dok, prog_rdy}, 3'b011);
    chk("prog_w1", data_read, mdl(2'd1, pa[21:9], pa[8:0], 1'b1));
    wait_ack(5'b00010, 60, "bank_after_prog_wait");
    ba_rd = 4'b0000; downloading = 1'b0;
    repeat (10) @(negedge clk);

    // reset in the middle of a read; request stays asserted throughout
    ba1_addr = 22'h01111; ba_rd = 4'b0010;
    wait_ack(5'b00010, 60, "pre_reset_ack_wait");
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_hs", {ackv, ba_dst, ba_dok, ba_rdy, prog_dst, prog_dok, prog_rdy}, 0);
    chk("midrst_cmd", cmd, C_INH);
    chk("midrst_oe", sdram_dq_oe, 0);
    chk("midrst_dqm", sdram_dqm, 2'b11);
    repeat (3) @(negedge clk);
    chk("midrst_no_rdy", ba_rdy, 0);
    rst_n = 1'b1;
    check_init("reinit");
    wait_ack(5'b00010, 60, "post_reinit_ack_wait");
    ba_rd = 4'b0000;
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
